// File: rtl/int_controller_if.sv
// Control-unit <-> interrupt controller bundle: raw irq lines, mask access, request/ack handshake.
// Combinational wiring only; the int_save_pc/int_done pulses act as the handshake.
// master = control-unit side, slave = controller side.
interface int_controller_if;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       int_save_pc;
  logic       int_done;
  logic       int_sig;
  logic [1:0] int_vector;
  logic [3:0] mask;
  logic [3:0] pending;
  logic       busy;

  modport master (
    output irq, mask_we, mask_wdata, int_save_pc, int_done,
    input  int_sig, int_vector, mask, pending, busy
  );

  modport slave (
    input  irq, mask_we, mask_wdata, int_save_pc, int_done,
    output int_sig, int_vector, mask, pending, busy
  );
endinterface

// File: rtl/int_controller.sv
// 4-source edge-triggered interrupt controller, fixed priority (bit 0 highest), no nesting.
// Latency: irq rise -> int_sig after 2 edges (4 with INTC_SYNC_EN, which adds a 2-flop irq synchronizer).
// Backpressure: requests wait in pending until int_save_pc; new edges only accumulate.
module int_controller (
  input  logic         clk,
  input  logic         rst,
  int_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] irq_src;
  logic [3:0] irq_q;
  logic [3:0] rise;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] enabled;
  logic [3:0] clr;
  logic [1:0] vec;
  logic [1:0] sel;
  logic       take;

`ifdef INTC_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= bus.irq;
      sync2 <= sync1;
    end
  end

  assign irq_src = sync2;
`else
  assign irq_src = bus.irq;
`endif

  assign rise    = irq_src & ~irq_q;
  assign enabled = pending & mask;

  always_comb begin
    sel = 2'd3;
    casez (enabled)
      4'b???1: sel = 2'd0;
      4'b??10: sel = 2'd1;
      4'b?100: sel = 2'd2;
      default: sel = 2'd3;
    endcase
  end

  // An acknowledge retires the serviced bit, but a fresh edge on that bit re-arms it.
  assign take = (state == REQ) && bus.int_save_pc;
  assign clr  = take ? (4'b0001 << vec) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= 4'b0000;
      pending <= 4'b0000;
      mask    <= 4'b0000;
    end else begin
      irq_q   <= irq_src;
      pending <= (pending & ~clr) | rise;
      if (bus.mask_we) begin
        mask <= bus.mask_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      vec   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|enabled) begin
            state <= REQ;
            vec   <= sel;
          end
        end
        // An acknowledge already in flight takes precedence over a late mask-off.
        REQ: begin
          if (bus.int_save_pc) begin
            state <= SERV;
          end else if (!mask[vec]) begin
            state <= IDLE;
          end
        end
        SERV: begin
          if (bus.int_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.int_sig    = (state == REQ);
  assign bus.busy       = (state == SERV);
  assign bus.int_vector = vec;
  assign bus.mask       = mask;
  assign bus.pending    = pending;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: reset, priority, masking, mask-drop, set-wins and level-hold cases.
module tb_int_controller;

`ifdef INTC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  int_controller_if bus ();

  int_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick(1);
    bus.mask_we    = 1'b0;
  endtask

  // Pulse irq for one cycle and wait until the edge has landed in pending.
  task automatic pulse_irq(input logic [3:0] v);
    bus.irq = v;
    tick(1);
    bus.irq = 4'b0000;
    if (SYNC > 0) tick(SYNC);
  endtask

  task automatic test_reset;
    tick(2);
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL reset_int_sig got %b want 0", bus.int_sig); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL reset_pending got %b want 0000", bus.pending); end
    tests++; if (bus.mask !== 4'b0000) begin fails++; $display("FAIL reset_mask got %b want 0000", bus.mask); end
    tests++; if (bus.int_vector !== 2'd0) begin fails++; $display("FAIL reset_vector got %0d want 0", bus.int_vector); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single;
    write_mask(4'b1111);
    tests++; if (bus.mask !== 4'b1111) begin fails++; $display("FAIL single_mask got %b want 1111", bus.mask); end
    pulse_irq(4'b0100);
    tests++; if (bus.pending !== 4'b0100) begin fails++; $display("FAIL single_pending got %b want 0100", bus.pending); end
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL single_sig_early got %b want 0", bus.int_sig); end
    tick(1);
    tests++; if (bus.int_sig !== 1'b1) begin fails++; $display("FAIL single_sig got %b want 1", bus.int_sig); end
    tests++; if (bus.int_vector !== 2'd2) begin fails++; $display("FAIL single_vector got %0d want 2", bus.int_vector); end
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", bus.busy); end
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL single_sig_serv got %b want 0", bus.int_sig); end
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL single_pending_clr got %b want 0000", bus.pending); end
    tests++; if (bus.int_vector !== 2'd2) begin fails++; $display("FAIL single_vector_hold got %0d want 2", bus.int_vector); end
    bus.int_done = 1'b1;
    tick(1);
    bus.int_done = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_done got %b want 0", bus.busy); end
    tick(1);
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL single_no_rereq got %b want 0", bus.int_sig); end
  endtask

  task automatic test_priority;
    pulse_irq(4'b1010);
    tests++; if (bus.pending !== 4'b1010) begin fails++; $display("FAIL prio_pending got %b want 1010", bus.pending); end
    tick(1);
    tests++; if (bus.int_sig !== 1'b1) begin fails++; $display("FAIL prio_sig got %b want 1", bus.int_sig); end
    tests++; if (bus.int_vector !== 2'd1) begin fails++; $display("FAIL prio_first got %0d want 1", bus.int_vector); end
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    tests++; if (bus.pending !== 4'b1000) begin fails++; $display("FAIL prio_pending_ack got %b want 1000", bus.pending); end
    bus.int_done = 1'b1;
    tick(1);
    bus.int_done = 1'b0;
    tests++; if (bus.int_sig !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL prio_idle got sig=%b busy=%b want 0 0", bus.int_sig, bus.busy); end
    tick(1);
    tests++; if (bus.int_sig !== 1'b1) begin fails++; $display("FAIL prio_second_sig got %b want 1", bus.int_sig); end
    tests++; if (bus.int_vector !== 2'd3) begin fails++; $display("FAIL prio_second got %0d want 3", bus.int_vector); end
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    bus.int_done = 1'b1;
    tick(1);
    bus.int_done = 1'b0;
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL prio_drained got %b want 0000", bus.pending); end
  endtask

  task automatic test_masked;
    write_mask(4'b0000);
    pulse_irq(4'b0001);
    tests++; if (bus.pending !== 4'b0001) begin fails++; $display("FAIL masked_pending got %b want 0001", bus.pending); end
    tick(2);
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL masked_sig got %b want 0", bus.int_sig); end
    write_mask(4'b0001);
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL masked_sig_wr got %b want 0", bus.int_sig); end
    tick(1);
    tests++; if (bus.int_sig !== 1'b1) begin fails++; $display("FAIL unmasked_sig got %b want 1", bus.int_sig); end
    tests++; if (bus.int_vector !== 2'd0) begin fails++; $display("FAIL unmasked_vector got %0d want 0", bus.int_vector); end
  endtask

  task automatic test_mask_drop;
    write_mask(4'b0000);
    tick(1);
    tests++; if (bus.int_sig !== 1'b0) begin fails++; $display("FAIL drop_sig got %b want 0", bus.int_sig); end
    tests++; if (bus.pending !== 4'b0001) begin fails++; $display("FAIL drop_pending got %b want 0001", bus.pending); end
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.pending !== 4'b0001) begin fails++; $display("FAIL ack_ignored got busy=%b pending=%b want 0 0001", bus.busy, bus.pending); end
    write_mask(4'b0001);
    tick(1);
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    bus.int_done = 1'b1;
    tick(1);
    bus.int_done = 1'b0;
    tests++; if (bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin fails++; $display("FAIL drop_cleanup got pending=%b busy=%b want 0000 0", bus.pending, bus.busy); end
  endtask

  task automatic test_set_wins;
    write_mask(4'b1111);
    pulse_irq(4'b0100);
    tick(1);
    tests++; if (bus.int_sig !== 1'b1 || bus.int_vector !== 2'd2) begin fails++; $display("FAIL setwin_req got sig=%b vec=%0d want 1 2", bus.int_sig, bus.int_vector); end
    bus.irq = 4'b0100;
    if (SYNC > 0) tick(SYNC);
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL setwin_busy got %b want 1", bus.busy); end
    tests++; if (bus.pending !== 4'b0100) begin fails++; $display("FAIL setwin_pending got %b want 0100", bus.pending); end
    bus.int_done = 1'b1;
    tick(1);
    bus.int_done = 1'b0;
    tick(1);
    tests++; if (bus.int_sig !== 1'b1 || bus.int_vector !== 2'd2) begin fails++; $display("FAIL level_rereq got sig=%b vec=%0d want 1 2", bus.int_sig, bus.int_vector); end
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL level_single_event got %b want 0000", bus.pending); end
    bus.int_done = 1'b1;
    tick(1);
    bus.int_done = 1'b0;
    bus.irq = 4'b0000;
    tick(SYNC + 2);
  endtask

  task automatic test_reset_mid;
    pulse_irq(4'b0011);
    tick(1);
    tests++; if (bus.int_sig !== 1'b1) begin fails++; $display("FAIL rstmid_pre got %b want 1", bus.int_sig); end
    bus.int_save_pc = 1'b1;
    tick(1);
    bus.int_save_pc = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.int_sig !== 1'b0) begin fails++; $display("FAIL rstmid_state got busy=%b sig=%b want 0 0", bus.busy, bus.int_sig); end
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL rstmid_pending got %b want 0000", bus.pending); end
    tests++; if (bus.mask !== 4'b0000) begin fails++; $display("FAIL rstmid_mask got %b want 0000", bus.mask); end
    tick(1);
    rst = 1'b0;
    tick(2);
    tests++; if (bus.pending !== 4'b0000 || bus.int_sig !== 1'b0) begin fails++; $display("FAIL rstmid_after got pending=%b sig=%b want 0000 0", bus.pending, bus.int_sig); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.irq = 4'b0000;
    bus.mask_we = 1'b0;
    bus.mask_wdata = 4'b0000;
    bus.int_save_pc = 1'b0;
    bus.int_done = 1'b0;
    test_reset;
    test_single;
    test_priority;
    test_masked;
    test_mask_drop;
    test_set_wins;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
